// File: rtl/pipo_shift_reg_if.sv
// Parallel data bundle for the PIPO word delay line: input word, delayed word
// and the pipeline-full flag.
interface pipo_shift_reg_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid;

  modport master (
    output data_in,
    input  data_out,
    input  valid
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid
  );
endinterface

// File: rtl/pipo_shift_reg.sv
// Fixed-latency parallel word delay: STAGES register stages of WIDTH bits,
// shifting on every rising edge, with a registered pipeline-full flag.
module pipo_shift_reg #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid
);

  localparam int unsigned         DEPTH = STAGES;
  localparam int                  CNT_W = (STAGES < 1) ? 1 : $clog2(STAGES + 1);
  localparam logic [CNT_W-1:0]    FULL  = CNT_W'(STAGES);

  if (STAGES < 1 || STAGES > 16) begin : g_cfg_err
    $error("pipo_shift_reg: STAGES must be within 1..16");
  end

  logic [WIDTH-1:0] stage [DEPTH];
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] fill_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= data_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Saturating fill count; independent of data so X on data_in cannot reach it.
  always_comb begin
    fill_cnt_nxt = fill_cnt;
    if (fill_cnt != FULL) begin
      fill_cnt_nxt = fill_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
      valid    <= 1'b0;
    end else begin
      fill_cnt <= fill_cnt_nxt;
      valid    <= (fill_cnt_nxt == FULL);
    end
  end

  assign data_out = stage[DEPTH-1];

endmodule

// File: tb/tb_pipo_shift_reg.sv
// Directed bench for pipo_shift_reg in three configurations sharing clock and reset.
module tb_pipo_shift_reg;

  logic clk;
  logic rst;

  pipo_shift_reg_if #(.WIDTH(4))  bus1 ();
  pipo_shift_reg_if #(.WIDTH(8))  bus3 ();
  pipo_shift_reg_if #(.WIDTH(16)) bus16 ();

  pipo_shift_reg #(.WIDTH(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .data_in(bus1.data_in),
    .data_out(bus1.data_out), .valid(bus1.valid));

  pipo_shift_reg #(.WIDTH(8), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .data_in(bus3.data_in),
    .data_out(bus3.data_out), .valid(bus3.valid));

  pipo_shift_reg #(.WIDTH(16), .STAGES(2)) u_w16 (
    .clk(clk), .rst(rst), .data_in(bus16.data_in),
    .data_out(bus16.data_out), .valid(bus16.valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  din1;  logic [3:0]  exp1;  logic ev1;
    logic [7:0]  din3;  logic [7:0]  exp3;  logic ev3;
    logic [15:0] din16; logic [15:0] exp16; logic ev16;
  } vec_t;

  vec_t vecs [5];

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'b1010, 4'b1010, 1'b1, 8'h11, 8'h00, 1'b0, 16'hA5C3, 16'h0000, 1'b0};
    vecs[1] = '{4'b1011, 4'b1011, 1'b1, 8'h22, 8'h00, 1'b0, 16'h3C5A, 16'hA5C3, 1'b1};
    vecs[2] = '{4'b1001, 4'b1001, 1'b1, 8'h33, 8'h11, 1'b1, 16'hFFFF, 16'h3C5A, 1'b1};
    vecs[3] = '{4'b0101, 4'b0101, 1'b1, 8'h44, 8'h22, 1'b1, 16'h0001, 16'hFFFF, 1'b1};
    vecs[4] = '{4'b1100, 4'b1100, 1'b1, 8'h55, 8'h33, 1'b1, 16'h8000, 16'h0001, 1'b1};

    rst = 1'b0;
    bus1.data_in  = 4'b1111;
    bus3.data_in  = 8'hFF;
    bus16.data_in = 16'hFFFF;

    // Reset held with the clock running and all-ones on the inputs.
    for (int c = 0; c < 2; c++) begin
      after_edge();
      check("rst_s1_out",   16'(bus1.data_out),  16'h0);
      check("rst_s1_valid", 16'(bus1.valid),     16'h0);
      check("rst_s3_out",   16'(bus3.data_out),  16'h0);
      check("rst_s3_valid", 16'(bus3.valid),     16'h0);
      check("rst_w16_out",  bus16.data_out,      16'h0);
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      bus1.data_in  = vecs[i].din1;
      bus3.data_in  = vecs[i].din3;
      bus16.data_in = vecs[i].din16;
      after_edge();
      check($sformatf("vec%0d_s1_out", i),    16'(bus1.data_out), 16'(vecs[i].exp1));
      check($sformatf("vec%0d_s1_valid", i),  16'(bus1.valid),    16'(vecs[i].ev1));
      check($sformatf("vec%0d_s3_out", i),    16'(bus3.data_out), 16'(vecs[i].exp3));
      check($sformatf("vec%0d_s3_valid", i),  16'(bus3.valid),    16'(vecs[i].ev3));
      check($sformatf("vec%0d_w16_out", i),   bus16.data_out,     vecs[i].exp16);
      check($sformatf("vec%0d_w16_valid", i), 16'(bus16.valid),   16'(vecs[i].ev16));
    end

    // Two input changes inside one period; only the value at the edge counts.
    @(negedge clk);
    bus1.data_in = 4'b0011;
    #2 bus1.data_in = 4'b0110;
    check("hold_between_edges", 16'(bus1.data_out), 16'(4'b1100));
    #1 bus1.data_in = 4'b1110;
    after_edge();
    check("hold_after_edge", 16'(bus1.data_out), 16'(4'b1110));

    // Asynchronous reset between edges.
    @(negedge clk);
    bus1.data_in = 4'b1011;
    after_edge();
    check("pre_areset_s1", 16'(bus1.data_out), 16'(4'b1011));
    #2 rst = 1'b0;
    #1;
    check("areset_s1_out",    16'(bus1.data_out), 16'h0);
    check("areset_s1_valid",  16'(bus1.valid),    16'h0);
    check("areset_s3_out",    16'(bus3.data_out), 16'h0);
    check("areset_s3_valid",  16'(bus3.valid),    16'h0);
    check("areset_w16_valid", 16'(bus16.valid),   16'h0);
    bus1.data_in = 4'b1111;
    bus3.data_in = 8'hEE;
    after_edge();
    check("areset_ignores_din", 16'(bus1.data_out), 16'h0);

    // Release, then X words on the data path; the fill logic must stay clean.
    @(negedge clk);
    rst = 1'b1;
    bus1.data_in = 4'b0110;
    bus3.data_in = 8'h5A;
    after_edge();
    check("release_s1_out",   16'(bus1.data_out), 16'(4'b0110));
    check("release_s1_valid", 16'(bus1.valid),    16'h1);
    check("release_s3_out",   16'(bus3.data_out), 16'h0);
    check("release_s3_valid", 16'(bus3.valid),    16'h0);

    @(negedge clk);
    bus1.data_in = 4'bx0x1;
    bus3.data_in = 8'hxx;
    after_edge();
    check("x_s1_out",   16'(bus1.data_out), {12'h000, 4'bx0x1});
    check("x_s1_valid", 16'(bus1.valid),    16'h1);
    check("x_s3_valid", 16'(bus3.valid),    16'h0);

    @(negedge clk);
    bus1.data_in = 4'b0001;
    bus3.data_in = 8'h7E;
    after_edge();
    check("x_s3_out_edge3",   16'(bus3.data_out), 16'h005A);
    check("x_s3_valid_edge3", 16'(bus3.valid),    16'h1);
    check("x_s1_recover",     16'(bus1.data_out), 16'(4'b0001));

    @(negedge clk);
    after_edge();
    check("x_s3_out_edge4", 16'(bus3.data_out), {8'h00, 8'hxx});
    check("x_s3_valid_kept", 16'(bus3.valid),   16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
